// File: rtl/hlsm_job_feeder.sv
// hlsm_job_feeder: operand FIFO, single-job launcher and result register
// that sit in front of the HLSM datapath core (Start/Done handshake).
// Optional watchdog: define HLSM_FEED_TIMEOUT_EN to add timeout_err and
// abandon jobs whose WAIT phase lasts TIMEOUT_CYC cycles.
module hlsm_job_feeder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CORE_LAT    = 6,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_c,
  output logic        core_start,
  input  logic        core_done,
  output logic [15:0] core_a,
  output logic [15:0] core_b,
  output logic [15:0] core_c,
  input  logic [7:0]  core_z,
  input  logic [15:0] core_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_z,
  output logic [15:0] out_x,
  output logic [15:0] job_cnt,
  output logic        busy
`ifdef HLSM_FEED_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WCW = $clog2(CORE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [47:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full;
  logic           push, pop, capture, timeout_hit;
  logic           wait_done;
  logic [WCW-1:0] wait_cnt;

`ifdef HLSM_FEED_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] to_cnt;
`endif

  // Extra pointer bit tells full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Held low while Rst is asserted so every output reads 0 during reset.
  assign in_ready   = !Rst && !fifo_full;
  assign push       = in_valid && in_ready;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign wait_done  = (wait_cnt == WCW'(CORE_LAT));

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (capture || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: launch pulse, FIFO pop, result capture, watchdog expiry
  always_comb begin
    core_start  = 1'b0;
    pop         = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE:  pop = !fifo_empty;
      START: core_start = 1'b1;
      WAIT: begin
        // Done is only honoured once the minimum latency has elapsed and the
        // result slot is free (or being emptied this very cycle).
        capture = wait_done && core_done && (!out_valid || out_ready);
`ifdef HLSM_FEED_TIMEOUT_EN
        timeout_hit = !capture && (to_cnt == TCW'(TIMEOUT_CYC - 1));
`endif
      end
      default: ;
    endcase
  end

  // FIFO pointers; push and pop may coincide
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // FIFO storage, packed as {a, b, c}
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {in_a, in_b, in_c};
  end

  // Operand registers: loaded only on the IDLE->START pop, held for the job
  always_ff @(posedge Clk) begin
    if (Rst) begin
      core_a <= '0;
      core_b <= '0;
      core_c <= '0;
    end else if (pop) begin
      {core_a, core_b, core_c} <= fifo_mem[rd_ptr[AW-1:0]];
    end
  end

  // Minimum-latency counter, cleared in START and saturating at CORE_LAT
  always_ff @(posedge Clk) begin
    if (Rst)                                wait_cnt <= '0;
    else if (state_q == START)              wait_cnt <= '0;
    else if (state_q == WAIT && !wait_done) wait_cnt <= wait_cnt + WCW'(1);
  end

  // Result register and completed-job counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_x     <= '0;
      job_cnt   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_z     <= core_z;
      out_x     <= core_x;
      job_cnt   <= job_cnt + 16'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HLSM_FEED_TIMEOUT_EN
  // Watchdog: counts WAIT cycles; a tripped job is dropped and the flag sticks
  always_ff @(posedge Clk) begin
    if (Rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == START)     to_cnt <= '0;
      else if (state_q == WAIT) to_cnt <= to_cnt + TCW'(1);
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hlsm_job_feeder.sv
// Bench for hlsm_job_feeder: directed scenarios plus a randomized phase,
// scored against a queue-based model of the push order and job accounting.
module tb_hlsm_job_feeder;
  localparam int FIFO_DEPTH  = 4;
  localparam int CORE_LAT    = 6;
  localparam int TIMEOUT_CYC = 64;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b, in_c;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [15:0] core_a, core_b, core_c;
  logic [7:0]  core_z;
  logic [15:0] core_x;
  logic        out_valid, out_ready;
  logic [7:0]  out_z;
  logic [15:0] out_x, job_cnt;
  logic        busy;
`ifdef HLSM_FEED_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 Clk = ~Clk;

  hlsm_job_feeder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CORE_LAT   (CORE_LAT),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .core_start(core_start),
    .core_done (core_done),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_c    (core_c),
    .core_z    (core_z),
    .core_x    (core_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_x     (out_x),
    .job_cnt   (job_cnt),
    .busy      (busy)
`ifdef HLSM_FEED_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  // Core arithmetic model: z = (a+b+c) mod 256, x = (a*b mod 65536) ^ c
  function automatic logic [7:0] mdl_z(input logic [15:0] a, b, c);
    logic [15:0] s;
    s = a + b + c;
    return s[7:0];
  endfunction
  function automatic logic [15:0] mdl_x(input logic [15:0] a, b, c);
    logic [15:0] p;
    p = a * b;
    return p ^ c;
  endfunction
  function automatic logic [23:0] mdl_res(input logic [15:0] a, b, c);
    return {mdl_z(a, b, c), mdl_x(a, b, c)};
  endfunction

  assign core_z = mdl_z(core_a, core_b, core_c);
  assign core_x = mdl_x(core_a, core_b, core_c);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model state
  int          cyc = 0;
  logic [23:0] exp_q[$];
  logic [47:0] launch_q[$];
  int          pushes = 0, starts = 0, accepted = 0;
  logic [47:0] hold_ops = '0;
  bit          prev_start = 0;
  logic [15:0] prev_job = '0;
  int          start_cyc = 0, lat_last = 0;
  bit          pend_pp = 0;
  int          pp_hits = 0;
  bit          prev_terr = 0;

  // Core behaviour: mode 0 = done rises dly cycles after start and stays high,
  // mode 1 = done tied high, mode 2 = done tied low
  int mode = 0, dly = CORE_LAT, since = 0;
  bit started = 0, rand_dly = 0;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Rst) begin
      started   = 0;
      core_done = 1'b0;
    end else begin
      if (core_start) begin
        started = 1;
        since   = 0;
        if (rand_dly) dly = $urandom_range(0, 12);
      end else if (since < 100000) begin
        since++;
      end
      case (mode)
        1:       core_done = 1'b1;
        2:       core_done = 1'b0;
        default: core_done = started && (since >= dly);
      endcase
    end
  end

  // Scoreboard / invariant monitor
  always @(negedge Clk) begin : mon
    int          occ;
    int          idx;
    bit          push_now;
    logic [23:0] e;
    if (Rst) begin
      exp_q.delete();
      launch_q.delete();
      pushes     = 0;
      starts     = 0;
      accepted   = 0;
      prev_start = 0;
      prev_job   = '0;
      pend_pp    = 0;
      prev_terr  = 0;
    end else begin
      if (core_start) begin
        check("start_width", 64'(prev_start), 64'(0));
        if (launch_q.size() == 0) check("launch_unexpected", 64'(1), 64'(0));
        else check("launch_ops", 64'({core_a, core_b, core_c}), 64'(launch_q.pop_front()));
        hold_ops  = {core_a, core_b, core_c};
        start_cyc = cyc;
        starts++;
        if (pend_pp) pp_hits++;
      end else if (starts > 0) begin
        check("ops_hold", 64'({core_a, core_b, core_c}), 64'(hold_ops));
      end
      prev_start = core_start;
`ifdef HLSM_FEED_TIMEOUT_EN
      if (timeout_err && !prev_terr) begin
        idx = out_valid ? 1 : 0;
        if (exp_q.size() > idx) exp_q.delete(idx);
      end
      prev_terr = timeout_err;
`endif
      if (job_cnt != prev_job) begin
        lat_last = cyc - start_cyc;
        check("min_latency", 64'(lat_last >= CORE_LAT + 2), 64'(1));
        prev_job = job_cnt;
      end
      check("job_cnt", 64'(job_cnt), 64'(16'(accepted + int'(out_valid))));
      occ = pushes - starts;
      check("in_ready", 64'(in_ready), 64'(occ < FIFO_DEPTH));
      if (occ > 0) check("busy_fifo", 64'(busy), 64'(1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_unexpected", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("out_result", 64'({out_z, out_x}), 64'(e));
        end
        accepted++;
      end
      push_now = in_valid && in_ready;
      pend_pp  = push_now && (occ == FIFO_DEPTH - 1);
      if (push_now) begin
        exp_q.push_back(mdl_res(in_a, in_b, in_c));
        launch_q.push_back({in_a, in_b, in_c});
        pushes++;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("push_stall", 64'(0), 64'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_job(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (job_cnt >= 16'(n)) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("wait_job", 64'(ok), 64'(1));
  endtask

  task automatic drain_all(input string tag);
    bit ok;
    ok        = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (exp_q.size() == 0 && !busy && !out_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    check({tag, "_done"}, 64'(ok), 64'(1));
    check({tag, "_acc"}, 64'(accepted), 64'(pushes));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] ra, rb, rc;
    logic [23:0] first_exp;
    logic [15:0] jc;
    bit          ok;

    Rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b0;
    first_exp = '0;
    tick();
    tick();
    // Reset values
    check("rst_ctrl", 64'({in_ready, core_start, out_valid, busy}), 64'(0));
    check("rst_ops", 64'({core_a, core_b, core_c}), 64'(0));
    check("rst_res", 64'({out_z, out_x, job_cnt}), 64'(0));
`ifdef HLSM_FEED_TIMEOUT_EN
    check("rst_terr", 64'(timeout_err), 64'(0));
`endif
    Rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'(1));

    // Single job (3,4,5), done raised CORE_LAT cycles after start
    out_ready = 1'b1;
    push(16'd3, 16'd4, 16'd5);
    wait_job(1);
    check("t1_out_valid", 64'(out_valid), 64'(1));
    check("t1_out", 64'({out_z, out_x}), 64'(mdl_res(16'd3, 16'd4, 16'd5)));
    check("t1_ops", 64'({core_a, core_b, core_c}), 64'({16'd3, 16'd4, 16'd5}));
    @(negedge Clk); #1;
    check("t1_latency", 64'(lat_last), 64'(CORE_LAT + 2));
    check("t1_starts", 64'(starts), 64'(1));
    tick();

    // Sticky done must not shorten the job
    mode = 1;
    push(16'd7, 16'd8, 16'd9);
    wait_job(2);
    @(negedge Clk); #1;
    check("t2_sticky_latency", 64'(lat_last), 64'(CORE_LAT + 2));
    tick(); tick(); tick();

    // Five pushes against a blocked output
    mode = 0; dly = 3; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
      if (i == 0) first_exp = mdl_res(ra, rb, rc);
      push(ra, rb, rc);
    end
    check("t3_full", 64'(in_ready), 64'(0));
    repeat (30) tick();
    check("t3_hold_valid", 64'(out_valid), 64'(1));
    check("t3_first", 64'({out_z, out_x}), 64'(first_exp));

    // Free the slot: the stalled job captures, then a push meets the pop at depth-1
    out_ready = 1'b1;
    tick();
    push(16'($urandom), 16'($urandom), 16'($urandom));
    check("t4_ready", 64'(in_ready), 64'(1));
    check("t4_busy", 64'(busy), 64'(1));
    drain_all("t4_drain");
    check("t4_pushpop_seen", 64'(pp_hits > 0), 64'(1));

    // Randomized traffic with random core latency
    rand_dly = 1;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_c      = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain_all("rand_drain");

    // Reset while a job is in WAIT and another is queued
    rand_dly = 0; dly = CORE_LAT; out_ready = 1'b1;
    push(16'($urandom), 16'($urandom), 16'($urandom));
    push(16'($urandom), 16'($urandom), 16'($urandom));
    repeat (3) tick();
    check("t5_in_wait", 64'(busy), 64'(1));
    Rst = 1'b1;
    tick();
    check("t5_rst_ctrl", 64'({in_ready, core_start, out_valid, busy}), 64'(0));
    check("t5_rst_ops", 64'({core_a, core_b, core_c}), 64'(0));
    check("t5_rst_res", 64'({out_z, out_x, job_cnt}), 64'(0));
    Rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t5_no_start", 64'({core_start, busy, out_valid}), 64'(0));
    end

`ifdef HLSM_FEED_TIMEOUT_EN
    // Watchdog: done never arrives
    mode = 2;
    jc = job_cnt;
    push(16'd11, 16'd12, 16'd13);
    ok = 0;
    for (int i = 0; i < TIMEOUT_CYC + 40; i++) begin
      if (timeout_err) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("t6_timeout_seen", 64'(ok), 64'(1));
    check("t6_timeout_latency", 64'(cyc - start_cyc), 64'(TIMEOUT_CYC + 1));
    check("t6_job_cnt", 64'(job_cnt), 64'(jc));
    check("t6_no_out", 64'(out_valid), 64'(0));
    mode = 0;
    push(16'd21, 16'd22, 16'd23);
    wait_job(int'(jc) + 1);
    check("t6_err_sticky", 64'(timeout_err), 64'(1));
    drain_all("t6_drain");
`else
    jc = '0;
    ok = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
